// File: rtl/alu_nibble_sequencer.sv
// Serially drives an external 4-bit ALU slice to perform one 4*NIBBLES-bit operation, LS nibble first.
// Optional macro ALU_SEQ_PIPE_EN: accept a new request in the same cycle the result is handed off.
module alu_nibble_sequencer #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic [3:0]             op_s,
    input  logic                   op_m,
    input  logic                   op_cin,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_cn,
    input  logic [3:0]             alu_f,
    input  logic                   alu_cn1,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   res,
    output logic                   res_cout,
    output logic                   res_zero
);
    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [W-1:0]   sh_a;
    logic [W-1:0]   sh_b;
    logic [W-1:0]   res_q;
    logic [W-1:0]   res_shift;
    logic [3:0]     s_q;
    logic           m_q;
    logic           carry_q;
    logic           cout_q;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           last;

    always_comb begin
`ifdef ALU_SEQ_PIPE_EN
        in_ready = (state == IDLE) || ((state == DONE) && out_ready);
`else
        in_ready = (state == IDLE);
`endif
        accept    = in_valid && in_ready;
        last      = (cnt == CW'(NIBBLES - 1));
        // Shift form keeps the insert legal when NIBBLES == 1 (no upper bits to keep).
        res_shift = res_q >> 4;
        res_shift[W-1 -: 4] = alu_f;
    end

    // accept covers both IDLE and, when pipelined, the DONE handoff cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh_a    <= '0;
            sh_b    <= '0;
            res_q   <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            sh_a    <= op_a;
            sh_b    <= op_b;
            s_q     <= op_s;
            m_q     <= op_m;
            carry_q <= op_cin;
            cnt     <= '0;
            state   <= RUN;
        end else begin
            case (state)
                RUN: begin
                    res_q   <= res_shift;
                    carry_q <= alu_cn1;
                    sh_a    <= sh_a >> 4;
                    sh_b    <= sh_b >> 4;
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        cout_q <= alu_cn1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        alu_a     = sh_a[3:0];
        alu_b     = sh_b[3:0];
        alu_s     = s_q;
        alu_m     = m_q;
        alu_cn    = carry_q;
        out_valid = (state == DONE);
        res       = res_q;
        res_cout  = cout_q;
        res_zero  = (res_q == '0);
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench for alu_nibble_sequencer with a behavioural 4-bit slice and a full-width reference model.
module tb_alu_nibble_sequencer;
    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;
    localparam int unsigned W1      = W + 1;
`ifdef ALU_SEQ_PIPE_EN
    localparam int PERIOD = NIBBLES + 1;
`else
    localparam int PERIOD = NIBBLES + 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [3:0]   op_s;
    logic         op_m;
    logic         op_cin;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [3:0]   alu_s;
    logic         alu_m;
    logic         alu_cn;
    logic [3:0]   alu_f;
    logic         alu_cn1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         res_cout;
    logic         res_zero;
    logic [4:0]   slice_sum;

    int checks   = 0;
    int failures = 0;

    alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
        .alu_f(alu_f), .alu_cn1(alu_cn1),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .res_cout(res_cout), .res_zero(res_zero)
    );

    always #5 clk = ~clk;

    // Slice: M=0 S=1001 add, S=0110 subtract (A + ~B + Cn); M=1 XOR/AND/OR/NOT with carry passed through.
    always_comb begin
        slice_sum = '0;
        alu_f     = '0;
        alu_cn1   = alu_cn;
        if (!alu_m) begin
            if (alu_s == 4'b0110) slice_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_cn};
            else                  slice_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cn};
            alu_f   = slice_sum[3:0];
            alu_cn1 = slice_sum[4];
        end else begin
            case (alu_s)
                4'b1010: alu_f = alu_a ^ alu_b;
                4'b1011: alu_f = alu_a & alu_b;
                4'b1110: alu_f = alu_a | alu_b;
                default: alu_f = ~alu_a;
            endcase
        end
    end

    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] s, input logic m, input logic cin);
        if (!m) begin
            if (s == 4'b0110) return {1'b0, a} + {1'b0, ~b} + W1'(cin);
            return {1'b0, a} + {1'b0, b} + W1'(cin);
        end
        case (s)
            4'b1010: return {cin, a ^ b};
            4'b1011: return {cin, a & b};
            4'b1110: return {cin, a | b};
            default: return {cin, ~a};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                          input logic m, input logic cin, input int hold,
                          output logic [W-1:0] r, output logic c, output logic z);
        int n;
        int lat;
        op_a = a; op_b = b; op_s = s; op_m = m; op_cin = cin;
        in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a = W'({$urandom, $urandom}); op_b = W'({$urandom, $urandom});
        op_s = 4'($urandom); op_m = ~m; op_cin = ~cin;
        lat = 0;
        while (!out_valid && lat < 50) begin
            if (lat < int'(NIBBLES)) begin
                chk("alu_a", 64'(alu_a), 64'(a[4*lat +: 4]));
                chk("alu_b", 64'(alu_b), 64'(b[4*lat +: 4]));
                chk("alu_s", 64'(alu_s), 64'(s));
                chk("alu_m", 64'(alu_m), 64'(m));
                chk("in_ready_run", 64'(in_ready), 64'(0));
                if (lat == 0) chk("alu_cn0", 64'(alu_cn), 64'(cin));
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(NIBBLES));
        r = res; c = res_cout; z = res_zero;
        if (hold > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            op_a = W'({$urandom, $urandom}); op_b = W'({$urandom, $urandom});
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_res", 64'(res), 64'(r));
                chk("hold_cout", 64'(res_cout), 64'(c));
                chk("hold_in_ready", 64'(in_ready), 64'(0));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("handoff_valid", 64'(out_valid), 64'(0));
        chk("handoff_ready", 64'(in_ready), 64'(1));
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   s;
        logic         m;
        logic         cin;
        logic [W-1:0] r;
        logic         cout;
    } vec_t;

    vec_t         vecs[4];
    logic [3:0]   s_tab[6];
    logic         m_tab[6];
    logic [W-1:0] got_r;
    logic         got_c;
    logic         got_z;
    logic [W:0]   exp_v;
    logic [W-1:0] tp_a[3];
    logic [W-1:0] tp_b[3];
    logic [W-1:0] tp_r[3];
    int           tp_t[3];
    int           idx;
    int           nres;
    logic         acc;

    initial begin
        vecs[0] = '{a: 16'h00FF, b: 16'h0001, s: 4'b1001, m: 1'b0, cin: 1'b0, r: 16'h0100, cout: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, s: 4'b1001, m: 1'b0, cin: 1'b0, r: 16'h0000, cout: 1'b1};
        vecs[2] = '{a: 16'hFFFE, b: 16'h0000, s: 4'b1001, m: 1'b0, cin: 1'b1, r: 16'hFFFF, cout: 1'b0};
        vecs[3] = '{a: 16'hA5A5, b: 16'h0FF0, s: 4'b1010, m: 1'b1, cin: 1'b0, r: 16'hAA55, cout: 1'b0};
        s_tab = '{4'b1001, 4'b0110, 4'b1010, 4'b1011, 4'b1110, 4'b0000};
        m_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cin = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_res", 64'(res), 64'(0));
        chk("rst_cout", 64'(res_cout), 64'(0));
        chk("rst_zero", 64'(res_zero), 64'(1));
        chk("rst_alu", 64'({alu_a, alu_b, alu_s, alu_m, alu_cn}), 64'(0));
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors; the first one also exercises 5 cycles of backpressure.
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].cin, (i == 0) ? 5 : 0,
                   got_r, got_c, got_z);
            chk($sformatf("vec%0d_res", i), 64'(got_r), 64'(vecs[i].r));
            if (!vecs[i].m) chk($sformatf("vec%0d_cout", i), 64'(got_c), 64'(vecs[i].cout));
            chk($sformatf("vec%0d_zero", i), 64'(got_z), 64'(vecs[i].r == '0));
        end

        // Reset two cycles into RUN aborts with everything cleared.
        op_a = 16'h1234; op_b = 16'h1111; op_s = 4'b1001; op_m = 1'b0; op_cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_res", 64'(res), 64'(0));
        chk("mid_rst_zero", 64'(res_zero), 64'(1));
        chk("mid_rst_alu", 64'({alu_a, alu_b, alu_s, alu_m, alu_cn}), 64'(0));
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 64'(in_ready), 64'(1));
        run_op(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0, 0, got_r, got_c, got_z);
        chk("post_rst_res", 64'(got_r), 64'(16'h2345));

        // Randomized operations against the full-width reference.
        for (int i = 0; i < 30; i++) begin
            int k;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            k  = int'($urandom_range(5, 0));
            ra = W'({$urandom, $urandom});
            rb = W'({$urandom, $urandom});
            rc = 1'($urandom);
            exp_v = ref_op(ra, rb, s_tab[k], m_tab[k], rc);
            run_op(ra, rb, s_tab[k], m_tab[k], rc, int'($urandom_range(2, 0)), got_r, got_c, got_z);
            chk("rand_res", 64'(got_r), 64'(exp_v[W-1:0]));
            if (!m_tab[k]) chk("rand_cout", 64'(got_c), 64'(exp_v[W]));
            chk("rand_zero", 64'(got_z), 64'(exp_v[W-1:0] == '0));
        end

        // Back-to-back adds with in_valid and out_ready held high.
        tp_a = '{16'h1111, 16'h0F0F, 16'h8000};
        tp_b = '{16'h2222, 16'h0101, 16'h8000};
        tp_r = '{0, 0, 0};
        tp_t = '{0, 0, 0};
        idx = 0; nres = 0;
        op_a = tp_a[0]; op_b = tp_b[0]; op_s = 4'b1001; op_m = 1'b0; op_cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && nres < 3; cyc++) begin
            acc = in_valid && in_ready;
            if (out_valid) begin
                tp_t[nres] = cyc;
                tp_r[nres] = res;
                nres++;
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 3) begin op_a = tp_a[idx]; op_b = tp_b[idx]; end
                else in_valid = 1'b0;
            end
        end
        chk("tp_count", 64'(nres), 64'(3));
        for (int i = 0; i < 3; i++) begin
            exp_v = ref_op(tp_a[i], tp_b[i], 4'b1001, 1'b0, 1'b0);
            chk($sformatf("tp_res%0d", i), 64'(tp_r[i]), 64'(exp_v[W-1:0]));
        end
        chk("tp_period1", 64'(tp_t[1] - tp_t[0]), 64'(PERIOD));
        chk("tp_period2", 64'(tp_t[2] - tp_t[1]), 64'(PERIOD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
